// File: rtl/a2d_resp_pkg.sv
// a2d_resp_pkg: shared frame constants and state type for the A2D SPI responder
package a2d_resp_pkg;
  localparam int FRAME_BITS = 16;
  localparam int CHNL_MSB = 13;
  localparam int CHNL_LSB = 11;
  localparam logic [11:0] AUTOINC_STEP = 12'h010;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/a2d_spi_resp_sync_edge.sv
// sync_edge: multi-flop synchronizer with history flop giving rise/fall strobes
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic synced,
  output logic rise,
  output logic fall
);
  logic [STAGES:0] sh_q, sh_d;
  always_comb begin
    sh_d = {sh_q[STAGES-1:0], d};
    synced = sh_q[STAGES-1];
    rise = sh_q[STAGES-1] & ~sh_q[STAGES];
    fall = ~sh_q[STAGES-1] & sh_q[STAGES];
  end
  always_ff @(posedge clk) sh_q <= rst ? '1 : sh_d;
endmodule

// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: ADC128S-style SPI responder serving 8x12-bit channels (A2D_RESP_AUTOINC_EN adds per-frame drift)
module a2d_spi_resp
  import a2d_resp_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [11:0] RST_VAL = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        ld_wr,
  input  logic [2:0]  ld_chnl,
  input  logic [11:0] ld_data,
  output logic        frm_done,
  output logic        frm_err,
  output logic [2:0]  cur_chnl
);
  localparam int BW = $clog2(SYNC_STAGES + 2);
  logic ss_r, ss_f, sc_r, sc_f, mo_s;
  logic ok, ss_rise, ss_fall, sclk_rise, sclk_fall;
  state_t state_q, state_d;
  logic [15:0] tx_q, tx_d, rx_q, rx_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] cur_q, cur_d;
  logic done_q, done_d, err_q, err_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [11:0] ch_q [NUM_CH];
  logic [11:0] ch_d [NUM_CH];
`ifdef A2D_RESP_AUTOINC_EN
  logic [2:0] srv_q, srv_d;
`endif
  sync_edge #(.STAGES(SYNC_STAGES)) u_ss (.clk(clk), .rst(rst), .d(SS_n), .synced(), .rise(ss_r), .fall(ss_f));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sc (.clk(clk), .rst(rst), .d(SCLK), .synced(), .rise(sc_r), .fall(sc_f));
  sync_edge #(.STAGES(SYNC_STAGES)) u_mo (.clk(clk), .rst(rst), .d(MOSI), .synced(mo_s), .rise(), .fall());
  always_comb begin
    blank_d = blank_q == '0 ? '0 : blank_q - 1'b1;
    ok = blank_q == '0;
    ss_rise = ok & ss_r;
    ss_fall = ok & ss_f;
    sclk_rise = ok & sc_r;
    sclk_fall = ok & sc_f;
    state_d = state_q;
    tx_d = tx_q;
    rx_d = rx_q;
    cnt_d = cnt_q;
    cur_d = cur_q;
    done_d = 1'b0;
    err_d = 1'b0;
`ifdef A2D_RESP_AUTOINC_EN
    srv_d = srv_q;
`endif
    if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d = SHIFT;
        tx_d = {4'h0, ch_q[cur_q]};
        rx_d = '0;
        cnt_d = '0;
`ifdef A2D_RESP_AUTOINC_EN
        srv_d = cur_q;
`endif
      end
    end else begin
      if (sclk_rise) begin
        rx_d = {rx_q[14:0], mo_s};
        cnt_d = cnt_q == 5'd31 ? cnt_q : cnt_q + 5'd1;
      end
      if (sclk_fall && cnt_q != '0) tx_d = {tx_q[14:0], 1'b0};
      if (ss_rise) begin
        state_d = IDLE;
        done_d = cnt_q == 5'(FRAME_BITS);
        err_d = ~done_d;
        cur_d = done_d ? rx_q[CHNL_MSB:CHNL_LSB] : cur_q;
      end
    end
    for (int i = 0; i < NUM_CH; i++) ch_d[i] = ch_q[i];
`ifdef A2D_RESP_AUTOINC_EN
    if (done_d) ch_d[srv_q] = ch_q[srv_q] + AUTOINC_STEP;
`endif
    if (ld_wr) ch_d[ld_chnl] = ld_data;
    MISO = (state_q == SHIFT) & tx_q[15];
    frm_done = done_q;
    frm_err = err_q;
    cur_chnl = cur_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q <= '0;
      rx_q <= '0;
      cnt_q <= '0;
      cur_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      blank_q <= BW'(SYNC_STAGES + 1);
      ch_q <= '{default: RST_VAL};
`ifdef A2D_RESP_AUTOINC_EN
      srv_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      cnt_q <= cnt_d;
      cur_q <= cur_d;
      done_q <= done_d;
      err_q <= err_d;
      blank_q <= blank_d;
      ch_q <= ch_d;
`ifdef A2D_RESP_AUTOINC_EN
      srv_q <= srv_d;
`endif
    end
  end
endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb_a2d_spi_resp: directed plus random frames checked against a channel/pipeline reference model
module tb_a2d_spi_resp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic SS_n = 1'b1;
  logic SCLK = 1'b0;
  logic MOSI = 1'b0;
  logic MISO;
  logic ld_wr = 1'b0;
  logic [2:0] ld_chnl = '0;
  logic [11:0] ld_data = '0;
  logic frm_done, frm_err;
  logic [2:0] cur_chnl;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [11:0] m_ch [8];
  logic [2:0] m_cur;
  logic [15:0] last_rd;
  a2d_spi_resp dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .ld_wr(ld_wr), .ld_chnl(ld_chnl), .ld_data(ld_data),
    .frm_done(frm_done), .frm_err(frm_err), .cur_chnl(cur_chnl)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (frm_done === 1'b1) done_cnt <= done_cnt + 1;
    if (frm_err === 1'b1) err_cnt <= err_cnt + 1;
  end
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_ch[i] = 12'h000;
    m_cur = '0;
  endtask
  task automatic host_wr(input logic [2:0] ch, input logic [11:0] dat);
    ld_chnl = ch;
    ld_data = dat;
    ld_wr = 1'b1;
    wait_clk(1);
    ld_wr = 1'b0;
    m_ch[ch] = dat;
  endtask
  task automatic sclk_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      MOSI = 1'($urandom);
      wait_clk(6);
      SCLK = 1'b1;
      wait_clk(6);
      SCLK = 1'b0;
    end
  endtask
  task automatic run_frame(input string tag, input logic [15:0] mosi, input int nbits,
                           input bit wr, input logic [2:0] wch, input logic [11:0] wdat);
    logic [15:0] got, exp, mask;
    logic [2:0] srv;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    srv = m_cur;
    exp = {4'h0, m_ch[m_cur]};
    got = '0;
    SS_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      MOSI = i < 16 ? mosi[15-i] : 1'($urandom);
      if (wr && i == 8) begin
        host_wr(wch, wdat);
        wait_clk(5);
      end else wait_clk(6);
      if (i < 16) got[15-i] = MISO;
      SCLK = 1'b1;
      wait_clk(6);
      SCLK = 1'b0;
    end
    wait_clk(6);
    SS_n = 1'b1;
    wait_clk(8);
    mask = nbits >= 16 ? 16'hFFFF : ~(16'hFFFF >> nbits);
    if (nbits == 16) begin
      m_cur = mosi[13:11];
`ifdef A2D_RESP_AUTOINC_EN
      m_ch[srv] = m_ch[srv] + 12'h010;
`endif
    end
    last_rd = got;
    chk({tag, "_miso"}, 32'(got & mask), 32'(exp & mask));
    chk({tag, "_cur"}, 32'(cur_chnl), 32'(m_cur));
    chk({tag, "_done"}, 32'(done_cnt - d0), (nbits == 16) ? 32'd1 : 32'd0);
    chk({tag, "_err"}, 32'(err_cnt - e0), (nbits == 16) ? 32'd0 : 32'd1);
  endtask
  initial begin
    int d0, e0;
    model_reset();
    wait_clk(2);
    rst = 1'b0;
    wait_clk(10);
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_cur", 32'(cur_chnl), 32'd0);
    chk("rst_done", 32'(done_cnt), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    host_wr(3'd0, 12'h0A5);
    host_wr(3'd3, 12'h7FF);
    run_frame("pipe1", 16'h1800, 16, 1'b0, 3'd0, 12'h000);
    chk("pipe1_const", 32'(last_rd), 32'h00A5);
    chk("pipe1_cur3", 32'(cur_chnl), 32'd3);
    run_frame("pipe2", 16'h0000, 16, 1'b1, 3'd3, 12'h123);
    chk("pipe2_const", 32'(last_rd), 32'h07FF);
    chk("pipe2_cur0", 32'(cur_chnl), 32'd0);
    run_frame("wr_a", 16'h1800, 16, 1'b0, 3'd0, 12'h000);
    run_frame("wr_b", 16'h2800, 16, 1'b0, 3'd0, 12'h000);
`ifndef A2D_RESP_AUTOINC_EN
    chk("wr_b_const", 32'(last_rd), 32'h0123);
`endif
    run_frame("pre_short", 16'h0000, 16, 1'b0, 3'd0, 12'h000);
    run_frame("short", 16'h2800, 9, 1'b0, 3'd0, 12'h000);
    run_frame("post_short", 16'h0000, 16, 1'b0, 3'd0, 12'h000);
    run_frame("long", 16'h3800, 20, 1'b0, 3'd0, 12'h000);
    d0 = done_cnt;
    e0 = err_cnt;
    SS_n = 1'b0;
    wait_clk(6);
    sclk_pulses(7);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    model_reset();
    sclk_pulses(9);
    wait_clk(6);
    SS_n = 1'b1;
    wait_clk(8);
    chk("rmid_done", 32'(done_cnt - d0), 32'd0);
    chk("rmid_err", 32'(err_cnt - e0), 32'd0);
    chk("rmid_cur", 32'(cur_chnl), 32'd0);
    run_frame("rmid_next", 16'h0000, 16, 1'b0, 3'd0, 12'h000);
    chk("rmid_const", 32'(last_rd), 32'h0000);
`ifdef A2D_RESP_AUTOINC_EN
    host_wr(3'd2, 12'hFF8);
    run_frame("ai_sel", 16'h1000, 16, 1'b0, 3'd0, 12'h000);
    run_frame("ai1", 16'h1000, 16, 1'b0, 3'd0, 12'h000);
    chk("ai1_const", 32'(last_rd), 32'h0FF8);
    run_frame("ai2", 16'h1000, 16, 1'b0, 3'd0, 12'h000);
    chk("ai2_const", 32'(last_rd), 32'h0008);
    run_frame("ai3", 16'h1000, 16, 1'b0, 3'd0, 12'h000);
    chk("ai3_const", 32'(last_rd), 32'h0018);
`endif
    for (int k = 0; k < 20; k++) begin
      int nb;
      if ($urandom_range(0, 1) == 0) host_wr(3'($urandom), 12'($urandom));
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
      run_frame($sformatf("rnd%0d", k), 16'($urandom), nb, 1'($urandom), 3'($urandom), 12'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
